// File: rtl/lupa_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lupa_sched_pkg: shared types and default timing for the LUPA300 scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
package lupa_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } sched_state_e;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_START1 = 2'd1;
  localparam logic [1:0] ADDR_START2 = 2'd2;
  localparam logic [1:0] ADDR_START3 = 2'd3;

  localparam int LUPA_CNT_W      = 20;
  localparam int LUPA_FOT_CYC    = 624;
  localparam int LUPA_DEF_PERIOD = 450000;
  localparam int LUPA_DEF_START1 = 652;
  localparam int LUPA_DEF_START2 = 400000;
  localparam int LUPA_DEF_START3 = 430000;

endpackage
`default_nettype wire

// File: rtl/lupa_sync2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lupa_sync2: two-flop synchronizer for sensor status lines (FV / LV)
// Rev 1.0
// ----------------------------------------------------------------------------
module lupa_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/lupa_exposure_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lupa_exposure_sched: LUPA300 master-mode INT_TIME1..3 / FOT scheduler with
// shadow timing registers applied atomically at period wrap.   Rev 1.0
// ----------------------------------------------------------------------------
module lupa_exposure_sched
  import lupa_sched_pkg::*;
#(
  parameter int CNT_W      = LUPA_CNT_W,
  parameter int FOT_CYC    = LUPA_FOT_CYC,
  parameter int DEF_PERIOD = LUPA_DEF_PERIOD,
  parameter int DEF_START1 = LUPA_DEF_START1,
  parameter int DEF_START2 = LUPA_DEF_START2,
  parameter int DEF_START3 = LUPA_DEF_START3
) (
  input  logic             iCLOCK_80,
  input  logic             rst_n,
  input  logic             cfg_done,
  input  logic             enable,
  input  logic             frame_valid,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             int_time1,
  output logic             int_time2,
  output logic             int_time3,
  output logic             fot,
  output logic             upd_ack,
  output logic             sched_err,
  output logic [15:0]      frame_cnt
);

  localparam logic [CNT_W-1:0] FOT_W = CNT_W'(FOT_CYC);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] per_q, st1_q, st2_q, st3_q;
  logic [CNT_W-1:0] sh_per_q, sh_st1_q, sh_st2_q, sh_st3_q;
  logic             int1_q, int2_q, int3_q, fot_q, ack_q;
  logic             fv_s;
  logic             wrap, apply, sh_ok, run_act;
  logic [CNT_W:0]   sh_lim;

  // Sync resets high so a fresh start always waits for a genuine low FV.
  lupa_sync2 #(.RST_VAL(1'b1)) u_fv_sync (
    .clk_i   (iCLOCK_80),
    .rst_n_i (rst_n),
    .d_i     (frame_valid),
    .q_o     (fv_s)
  );

  assign wrap    = (state_q == RUN) && (cnt_q == per_q - ONE);
  assign apply   = pend_q && ((state_q == IDLE) || (wrap && cfg_done));
  assign sh_lim  = {1'b0, sh_st3_q} + {1'b0, FOT_W};
  assign sh_ok   = (sh_per_q > FOT_W) && (sh_st1_q <= sh_st2_q) &&
                   (sh_st2_q <= sh_st3_q) && (sh_lim < {1'b0, sh_per_q});
  assign run_act = (state_q == RUN) && cfg_done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable && cfg_done) state_d = ARM;
      end
      ARM: begin
        cnt_d = '0;
        if (!fv_s) state_d = RUN;
      end
      RUN: begin
        if (wrap) begin
          cnt_d  = '0;
          fcnt_d = fcnt_q + 16'd1;
          if (!enable) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Loss of sensor configuration aborts the period without counting it.
    if (!cfg_done) begin
      state_d = IDLE;
      cnt_d   = '0;
      fcnt_d  = fcnt_q;
    end

    pend_d = cfg_wr ? 1'b1 : (apply ? 1'b0 : pend_q);
    err_d  = err_q;
    if (cfg_wr)          err_d = 1'b0;
    if (apply && !sh_ok) err_d = 1'b1;
  end

  always_ff @(posedge iCLOCK_80) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      int1_q   <= 1'b1;
      int2_q   <= 1'b1;
      int3_q   <= 1'b1;
      fot_q    <= 1'b0;
      per_q    <= CNT_W'(DEF_PERIOD);
      st1_q    <= CNT_W'(DEF_START1);
      st2_q    <= CNT_W'(DEF_START2);
      st3_q    <= CNT_W'(DEF_START3);
      sh_per_q <= CNT_W'(DEF_PERIOD);
      sh_st1_q <= CNT_W'(DEF_START1);
      sh_st2_q <= CNT_W'(DEF_START2);
      sh_st3_q <= CNT_W'(DEF_START3);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      ack_q   <= apply && sh_ok;
      int1_q  <= !(run_act && (cnt_q >= st1_q));
      int2_q  <= !(run_act && (cnt_q >= st2_q));
      int3_q  <= !(run_act && (cnt_q >= st3_q));
      fot_q   <= run_act && (cnt_q >= per_q - FOT_W);
      if (apply && sh_ok) begin
        per_q <= sh_per_q;
        st1_q <= sh_st1_q;
        st2_q <= sh_st2_q;
        st3_q <= sh_st3_q;
      end
      if (cfg_wr) begin
        unique case (cfg_addr)
          ADDR_PERIOD: sh_per_q <= cfg_data;
          ADDR_START1: sh_st1_q <= cfg_data;
          ADDR_START2: sh_st2_q <= cfg_data;
          ADDR_START3: sh_st3_q <= cfg_data;
          default:     sh_per_q <= cfg_data;
        endcase
      end
    end
  end

  assign int_time1 = int1_q;
  assign int_time2 = int2_q;
  assign int_time3 = int3_q;
  assign fot       = fot_q;
  assign upd_ack   = ack_q;
  assign sched_err = err_q;
  assign frame_cnt = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lupa_exposure_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lupa_exposure_sched: directed, table-driven check of the exposure scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_lupa_exposure_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_done = 1'b0;
  logic        enable = 1'b0;
  logic        frame_valid = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [19:0] cfg_data = '0;
  logic        int_time1, int_time2, int_time3, fot, upd_ack, sched_err;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lupa_exposure_sched dut (
    .iCLOCK_80   (clk),
    .rst_n       (rst_n),
    .cfg_done    (cfg_done),
    .enable      (enable),
    .frame_valid (frame_valid),
    .cfg_wr      (cfg_wr),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .int_time1   (int_time1),
    .int_time2   (int_time2),
    .int_time3   (int_time3),
    .fot         (fot),
    .upd_ack     (upd_ack),
    .sched_err   (sched_err),
    .frame_cnt   (frame_cnt)
  );

  typedef struct {
    string       nm;
    int          ticks;
    logic        rst_n, cd, en, fv, wr;
    logic [1:0]  addr;
    logic [19:0] data;
    logic [5:0]  pins;   // {int1, int2, int3, fot, upd_ack, sched_err}
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input int ticks, input logic r, input logic cd,
                     input logic en, input logic fv, input logic wr, input logic [1:0] a,
                     input int d, input logic [5:0] pins, input int fc);
    vec_t v;
    v.nm = nm; v.ticks = ticks; v.rst_n = r; v.cd = cd; v.en = en; v.fv = fv;
    v.wr = wr; v.addr = a; v.data = 20'(d); v.pins = pins; v.fc = 16'(fc);
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic ack_seen;
    // After the rst_n release, RUN is entered on the 3rd edge (cnt=0); each pin
    // reflects the counter value from the previous cycle.
    //   name   ticks rst cd en fv wr addr data   {i1 i2 i3 fot ack err}  fc
    add("reset",   3, 0, 1, 1, 0, 0, 0, 0,    6'b111000, 0);
    add("i1_pre",655, 1, 1, 1, 0, 0, 0, 0,    6'b111000, 0);
    add("i1_fall", 1, 1, 1, 1, 0, 0, 0, 0,    6'b011000, 0);
    add("cnt800",147, 1, 1, 1, 0, 0, 0, 0,    6'b011000, 0);
    add("cd_drop", 1, 1, 0, 1, 1, 0, 0, 0,    6'b111000, 0);
    add("idle_w1", 1, 1, 0, 1, 1, 1, 1, 100,  6'b111000, 0);
    add("idle_w2", 1, 1, 0, 1, 1, 1, 2, 900,  6'b111010, 0);
    add("idle_w3", 1, 1, 0, 1, 1, 1, 3, 1300, 6'b111010, 0);
    add("idle_w4", 1, 1, 0, 1, 1, 1, 0, 2000, 6'b111010, 0);
    add("idle_a4", 1, 1, 0, 1, 1, 0, 0, 0,    6'b111010, 0);
    add("idle_q",  1, 1, 0, 1, 1, 0, 0, 0,    6'b111000, 0);
    add("arm_fv1", 5, 1, 1, 1, 1, 0, 0, 0,    6'b111000, 0);
    add("run_99", 103,1, 1, 1, 0, 0, 0, 0,    6'b111000, 0);
    add("run_100", 1, 1, 1, 1, 0, 0, 0, 0,    6'b011000, 0);
    add("run_899",799,1, 1, 1, 0, 0, 0, 0,    6'b011000, 0);
    add("run_900", 1, 1, 1, 1, 0, 0, 0, 0,    6'b001000, 0);
    add("run_1299",399,1,1, 1, 0, 0, 0, 0,    6'b001000, 0);
    add("run_1300",1, 1, 1, 1, 0, 0, 0, 0,    6'b000000, 0);
    add("run_1375",75,1, 1, 1, 0, 0, 0, 0,    6'b000000, 0);
    add("fot_1376",1, 1, 1, 1, 0, 0, 0, 0,    6'b000100, 0);
    add("wrap1",  623,1, 1, 1, 0, 0, 0, 0,    6'b000100, 1);
    add("p2_c0",   1, 1, 1, 1, 0, 0, 0, 0,    6'b111000, 1);
    add("mid_wr", 10, 1, 1, 1, 0, 1, 1, 200,  6'b111000, 1);
    add("pre_wr2",1988,1,1, 1, 0, 0, 0, 0,    6'b000100, 1);
    add("ack_wr2", 1, 1, 1, 1, 0, 0, 0, 0,    6'b000110, 2);
    add("ack_off", 1, 1, 1, 1, 0, 0, 0, 0,    6'b111000, 2);
    add("s1_199", 199,1, 1, 1, 0, 0, 0, 0,    6'b111000, 2);
    add("s1_200",  1, 1, 1, 1, 0, 0, 0, 0,    6'b011000, 2);
    add("bad_wr",  1, 1, 1, 1, 0, 1, 3, 1500, 6'b011000, 2);
    add("pre_wr3",1797,1,1, 1, 0, 0, 0, 0,    6'b000100, 2);
    add("rejected",1, 1, 1, 1, 0, 0, 0, 0,    6'b000101, 3);
    add("old_1299",1300,1,1,1, 0, 0, 0, 0,    6'b001001, 3);
    add("old_1300",1, 1, 1, 1, 0, 0, 0, 0,    6'b000001, 3);
    add("err_clr", 1, 1, 1, 1, 0, 1, 3, 1200, 6'b000000, 3);
    add("pre_wr4",697,1, 1, 1, 0, 0, 0, 0,    6'b000100, 3);
    add("wrap_wr", 1, 1, 1, 1, 0, 1, 1, 300,  6'b000110, 4);
    add("keep200",200,1, 1, 1, 0, 0, 0, 0,    6'b111000, 4);
    add("k_200",   1, 1, 1, 1, 0, 0, 0, 0,    6'b011000, 4);
    add("s3_1199",999,1, 1, 1, 0, 0, 0, 0,    6'b001000, 4);
    add("s3_1200", 1, 1, 1, 1, 0, 0, 0, 0,    6'b000000, 4);
    add("wrap5",  799,1, 1, 1, 0, 0, 0, 0,    6'b000110, 5);
    add("s1_299", 300,1, 1, 1, 0, 0, 0, 0,    6'b111000, 5);
    add("s1_300",  1, 1, 1, 1, 0, 0, 0, 0,    6'b011000, 5);
    add("en_off", 199,1, 1, 0, 0, 0, 0, 0,    6'b011000, 5);
    add("en_1998",1499,1,1, 0, 0, 0, 0, 0,    6'b000100, 5);
    add("en_wrap", 1, 1, 1, 0, 0, 0, 0, 0,    6'b000100, 6);
    add("en_idle", 1, 1, 1, 0, 0, 0, 0, 0,    6'b111000, 6);
    add("en_stay",50, 1, 1, 0, 0, 0, 0, 0,    6'b111000, 6);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; cfg_done = vecs[i].cd; enable = vecs[i].en;
      frame_valid = vecs[i].fv; cfg_wr = vecs[i].wr;
      cfg_addr = vecs[i].addr; cfg_data = vecs[i].data;
      for (int t = 0; t < vecs[i].ticks; t++) begin
        tick();
        cfg_wr = 1'b0;
      end
      chk({vecs[i].nm, ".int1"}, 16'(int_time1), 16'(vecs[i].pins[5]));
      chk({vecs[i].nm, ".int2"}, 16'(int_time2), 16'(vecs[i].pins[4]));
      chk({vecs[i].nm, ".int3"}, 16'(int_time3), 16'(vecs[i].pins[3]));
      chk({vecs[i].nm, ".fot"},  16'(fot),       16'(vecs[i].pins[2]));
      chk({vecs[i].nm, ".ack"},  16'(upd_ack),   16'(vecs[i].pins[1]));
      chk({vecs[i].nm, ".err"},  16'(sched_err), 16'(vecs[i].pins[0]));
      chk({vecs[i].nm, ".fcnt"}, frame_cnt,      vecs[i].fc);
    end

    // Mid-period reset must discard a pending shadow write and restore defaults.
    enable = 1'b1;
    repeat (20) tick();
    cfg_wr = 1'b1; cfg_addr = 2'd1; cfg_data = 20'd5;
    tick();
    cfg_wr = 1'b0;
    repeat (400) tick();
    chk("prerst.int1", 16'(int_time1), 16'd0);
    rst_n = 1'b0;
    tick();
    chk("midrst.int1", 16'(int_time1), 16'd1);
    chk("midrst.fcnt", frame_cnt, 16'd0);
    rst_n = 1'b1;
    ack_seen = 1'b0;
    for (int t = 0; t < 655; t++) begin
      tick();
      if (upd_ack) ack_seen = 1'b1;
    end
    chk("postrst.i1_hi", 16'(int_time1), 16'd1);
    tick();
    if (upd_ack) ack_seen = 1'b1;
    chk("postrst.i1_lo", 16'(int_time1), 16'd0);
    chk("postrst.no_ack", 16'(ack_seen), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
